unidade_busca: RTL and testbench

Instruction fetch stage feeding the instruction decoder (`decodificador`). It holds the program counter, fetches one 32-bit word at a time from instruction memory over a req/ack handshake, and buffers the word with its PC. It presents the word downstream under a valid/ready handshake. Branch and jump redirects computed from decoded fields restart fetch at the new target and squash any in-flight or buffered instruction.

---
 rtl/unidade_busca.sv | 180 ++++++++++++++++++
 tb/tb_unidade_busca.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/unidade_busca.sv
// Instruction fetch stage: PC, single-outstanding req/ack fetch, one-entry buffer to the decoder.
// Latency: ack at edge N -> inst_valid from N+1; accept at edge M -> next request in cycle M+1.
// Backpressure: inst_ready=0 holds the buffered word and stops fetching; redirects squash it.
// Optional feature macro: FETCH_ALIGN_CHECK_EN (misaligned redirect target -> sticky error, PARADO).
module unidade_busca #(
  parameter logic [31:0] PC_RESET = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic [31:0] instrucao,
  output logic [31:0] pc_out,
  output logic        inst_valid,
  input  logic        inst_ready,
  input  logic        redir_en,
  input  logic        redir_tipo,
  input  logic [31:0] redir_pc,
  input  logic [25:0] redir_imm,
  output logic        erro_alinhamento
);

  typedef enum logic [2:0] {
    INICIO   = 3'd0,
    BUSCA    = 3'd1,
    DESCARTA = 3'd2,
    CHEIO    = 3'd3
`ifdef FETCH_ALIGN_CHECK_EN
    ,
    PARADO   = 3'd4
`endif
  } estado_t;

  estado_t     estado_q, estado_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] end_req_q, end_req_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc_buf_q, pc_buf_d;
  logic [31:0] pc_novo;
  logic [31:0] p4;
  logic [31:0] alvo_bruto;
  logic [31:0] alvo;
`ifdef FETCH_ALIGN_CHECK_EN
  logic        erro_q, erro_d;
  logic        alvo_desalinhado;
`endif

  // Redirect target: branch is PC+4 relative, jump keeps the upper nibble of PC+4
  always_comb begin
    p4 = redir_pc + 32'd4;
    if (redir_tipo) begin
      alvo_bruto = {p4[31:28], redir_imm, 2'b00};
    end else begin
      alvo_bruto = p4 + {{14{redir_imm[15]}}, redir_imm[15:0], 2'b00};
    end
`ifdef FETCH_ALIGN_CHECK_EN
    alvo             = alvo_bruto;
    alvo_desalinhado = |alvo_bruto[1:0];
`else
    // Without the check, a misaligned target is silently rounded down to a word
    alvo = alvo_bruto & ~32'd3;
`endif
  end

  // Next-state and datapath updates
  always_comb begin
    estado_d  = estado_q;
    pc_d      = pc_q;
    end_req_d = end_req_q;
    instr_d   = instr_q;
    pc_buf_d  = pc_buf_q;
    pc_novo   = redir_en ? alvo : pc_q;
`ifdef FETCH_ALIGN_CHECK_EN
    erro_d    = erro_q;
`endif
    case (estado_q)
      INICIO: begin
        estado_d  = BUSCA;
        pc_d      = PC_RESET;
        end_req_d = PC_RESET;
      end
      BUSCA: begin
        if (redir_en) begin
          pc_d = alvo;
          if (mem_ack) begin
            // Returned word belongs to the old path: drop it and fetch the target now
            end_req_d = alvo;
          end else begin
            // Request is still in flight; its address must stay put until the ack
            estado_d = DESCARTA;
          end
        end else if (mem_ack) begin
          instr_d  = mem_rdata;
          pc_buf_d = end_req_q;
          pc_d     = end_req_q + 32'd4;
          estado_d = CHEIO;
        end
      end
      DESCARTA: begin
        // Newest redirect wins; the stale word is thrown away on ack
        pc_d = pc_novo;
        if (mem_ack) begin
          end_req_d = pc_novo;
          estado_d  = BUSCA;
        end
      end
      CHEIO: begin
        if (redir_en) begin
          pc_d      = alvo;
          end_req_d = alvo;
          estado_d  = BUSCA;
        end else if (inst_ready) begin
          end_req_d = pc_q;
          estado_d  = BUSCA;
        end
      end
`ifdef FETCH_ALIGN_CHECK_EN
      PARADO: begin
        estado_d = PARADO;
      end
`endif
      default: begin
        estado_d = INICIO;
      end
    endcase
`ifdef FETCH_ALIGN_CHECK_EN
    // A misaligned target halts fetch entirely; only reset recovers
    if (redir_en && alvo_desalinhado &&
        (estado_q == BUSCA || estado_q == DESCARTA || estado_q == CHEIO)) begin
      estado_d  = PARADO;
      erro_d    = 1'b1;
      pc_d      = pc_q;
      end_req_d = end_req_q;
      instr_d   = instr_q;
      pc_buf_d  = pc_buf_q;
    end
`endif
  end

  // State register with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      estado_q  <= INICIO;
      pc_q      <= PC_RESET;
      end_req_q <= PC_RESET;
      instr_q   <= 32'd0;
      pc_buf_q  <= 32'd0;
`ifdef FETCH_ALIGN_CHECK_EN
      erro_q    <= 1'b0;
`endif
    end else begin
      estado_q  <= estado_d;
      pc_q      <= pc_d;
      end_req_q <= end_req_d;
      instr_q   <= instr_d;
      pc_buf_q  <= pc_buf_d;
`ifdef FETCH_ALIGN_CHECK_EN
      erro_q    <= erro_d;
`endif
    end
  end

  // Outputs decoded from state
  always_comb begin
    mem_req    = (estado_q == BUSCA) || (estado_q == DESCARTA);
    inst_valid = (estado_q == CHEIO);
  end

  assign mem_addr  = end_req_q;
  assign instrucao = instr_q;
  assign pc_out    = pc_buf_q;
`ifdef FETCH_ALIGN_CHECK_EN
  assign erro_alinhamento = erro_q;
`else
  assign erro_alinhamento = 1'b0;
`endif

endmodule

// File: tb/tb_unidade_busca.sv
// Directed bench for unidade_busca: fetch, stall, jump, branch during a slow fetch,
// simultaneous redirect/accept, zero-wait throughput and misaligned-target handling.
module tb_unidade_busca;

  logic        clk;
  logic        reset;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic [31:0] instrucao;
  logic [31:0] pc_out;
  logic        inst_valid;
  logic        inst_ready;
  logic        redir_en;
  logic        redir_tipo;
  logic [31:0] redir_pc;
  logic [25:0] redir_imm;
  logic        erro_alinhamento;

  int checks  = 0;
  int errors  = 0;
  int accepts = 0;

  unidade_busca #(.PC_RESET(32'h0000_0000)) dut (
    .clk              (clk),
    .reset            (reset),
    .mem_req          (mem_req),
    .mem_addr         (mem_addr),
    .mem_ack          (mem_ack),
    .mem_rdata        (mem_rdata),
    .instrucao        (instrucao),
    .pc_out           (pc_out),
    .inst_valid       (inst_valid),
    .inst_ready       (inst_ready),
    .redir_en         (redir_en),
    .redir_tipo       (redir_tipo),
    .redir_pc         (redir_pc),
    .redir_imm        (redir_imm),
    .erro_alinhamento (erro_alinhamento)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: count a decoder handshake seen before the edge, then settle 1 time unit after it
  task automatic step();
    if (inst_valid === 1'b1 && inst_ready === 1'b1) accepts++;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset      = 1'b1;
    mem_ack    = 1'b0;
    mem_rdata  = 32'd0;
    inst_ready = 1'b0;
    redir_en   = 1'b0;
    redir_tipo = 1'b0;
    redir_pc   = 32'd0;
    redir_imm  = 26'd0;

    step(); step(); step();
    check("rst_mem_req", mem_req, 1'b0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_valid", inst_valid, 1'b0);
    check("rst_instrucao", instrucao, 32'h0);
    check("rst_pc_out", pc_out, 32'h0);
    check("rst_erro", erro_alinhamento, 1'b0);

    // First cycle after release: still INICIO, no request
    reset = 1'b0;
    #1;
    check("rel_c1_mem_req", mem_req, 1'b0);
    step();
    check("rel_c2_mem_req", mem_req, 1'b1);
    check("rel_c2_mem_addr", mem_addr, 32'h0);

    // Zero-wait fetch of the first word
    mem_ack   = 1'b1;
    mem_rdata = 32'h8D2804B0;
    step();
    mem_ack = 1'b0;
    check("f0_valid", inst_valid, 1'b1);
    check("f0_instrucao", instrucao, 32'h8D2804B0);
    check("f0_pc_out", pc_out, 32'h0);
    check("f0_mem_req", mem_req, 1'b0);

    // Decoder stalls for 5 cycles
    for (int i = 0; i < 5; i++) begin
      step();
      check("stall_valid", inst_valid, 1'b1);
      check("stall_instrucao", instrucao, 32'h8D2804B0);
      check("stall_mem_req", mem_req, 1'b0);
    end

    // Accept -> next request at PC+4
    inst_ready = 1'b1;
    step();
    inst_ready = 1'b0;
    check("acc_mem_req", mem_req, 1'b1);
    check("acc_mem_addr", mem_addr, 32'h4);
    check("acc_valid", inst_valid, 1'b0);

    mem_ack   = 1'b1;
    mem_rdata = 32'h1111_1111;
    step();
    mem_ack = 1'b0;
    check("f4_instrucao", instrucao, 32'h1111_1111);
    check("f4_pc_out", pc_out, 32'h4);

    // Jump from CHEIO: p4=0x14, target={0,0x2C0,00}=0xB00; buffered word dropped
    redir_en   = 1'b1;
    redir_tipo = 1'b1;
    redir_pc   = 32'h0000_0010;
    redir_imm  = 26'h00002C0;
    step();
    redir_en = 1'b0;
    check("jmp_mem_addr", mem_addr, 32'h0000_0B00);
    check("jmp_mem_req", mem_req, 1'b1);
    check("jmp_valid", inst_valid, 1'b0);

    // Branch while the fetch at 0xB00 takes 3 cycles: 0x104 + (-2<<2) = 0xFC
    redir_en   = 1'b1;
    redir_tipo = 1'b0;
    redir_pc   = 32'h0000_0100;
    redir_imm  = 26'h000FFFE;
    step();
    redir_en = 1'b0;
    check("br_hold_addr1", mem_addr, 32'h0000_0B00);
    check("br_hold_req1", mem_req, 1'b1);
    check("br_valid1", inst_valid, 1'b0);
    step();
    check("br_hold_addr2", mem_addr, 32'h0000_0B00);
    mem_ack   = 1'b1;
    mem_rdata = 32'hDEAD_BEEF;
    step();
    mem_ack = 1'b0;
    check("br_discard_valid", inst_valid, 1'b0);
    check("br_target_addr", mem_addr, 32'h0000_00FC);
    check("br_target_req", mem_req, 1'b1);

    mem_ack   = 1'b1;
    mem_rdata = 32'h2222_2222;
    step();
    mem_ack = 1'b0;
    check("fFC_valid", inst_valid, 1'b1);
    check("fFC_instrucao", instrucao, 32'h2222_2222);
    check("fFC_pc_out", pc_out, 32'h0000_00FC);

    // Redirect and accept at the same edge: jump to {3, 0x40<<2} = 0x3000_0100
    inst_ready = 1'b1;
    redir_en   = 1'b1;
    redir_tipo = 1'b1;
    redir_pc   = 32'h3000_0000;
    redir_imm  = 26'h0000040;
    step();
    redir_en   = 1'b0;
    inst_ready = 1'b0;
    check("sim_mem_addr", mem_addr, 32'h3000_0100);
    check("sim_valid", inst_valid, 1'b0);
    check("sim_mem_req", mem_req, 1'b1);
    step();
    check("sim_accepts", accepts, 2);
    check("sim_hold_addr", mem_addr, 32'h3000_0100);

    // Zero-wait memory with ready held high: one word every 2 cycles
    mem_ack    = 1'b1;
    mem_rdata  = 32'h3333_3333;
    inst_ready = 1'b1;
    step();
    check("tp_valid1", inst_valid, 1'b1);
    check("tp_pc_out1", pc_out, 32'h3000_0100);
    step();
    check("tp_addr1", mem_addr, 32'h3000_0104);
    check("tp_valid1_off", inst_valid, 1'b0);
    step();
    check("tp_pc_out2", pc_out, 32'h3000_0104);
    step();
    check("tp_addr2", mem_addr, 32'h3000_0108);
    mem_ack    = 1'b0;
    inst_ready = 1'b0;
    check("tp_accepts", accepts, 4);

    // Misaligned branch target: 0x2 + 4 = 0x6
    redir_en   = 1'b1;
    redir_tipo = 1'b0;
    redir_pc   = 32'h0000_0002;
    redir_imm  = 26'h0000000;
    step();
    redir_en = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
    check("al_erro", erro_alinhamento, 1'b1);
    check("al_mem_req", mem_req, 1'b0);
    check("al_valid", inst_valid, 1'b0);
    mem_ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("al_stuck_req", mem_req, 1'b0);
      check("al_stuck_erro", erro_alinhamento, 1'b1);
    end
    mem_ack = 1'b0;
`else
    // Request at 0x3000_0108 is still pending; target 6 is rounded to 4
    check("al_hold_addr", mem_addr, 32'h3000_0108);
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    check("al_round_addr", mem_addr, 32'h0000_0004);
    check("al_erro0", erro_alinhamento, 1'b0);
    check("al_valid0", inst_valid, 1'b0);
`endif

    // Reset mid-transaction, then restart from PC_RESET
    reset = 1'b1;
    step();
    check("rst2_mem_req", mem_req, 1'b0);
    check("rst2_mem_addr", mem_addr, 32'h0);
    check("rst2_erro", erro_alinhamento, 1'b0);
    check("rst2_valid", inst_valid, 1'b0);
    reset = 1'b0;
    step();
    check("rst2_c2_mem_req", mem_req, 1'b1);
    check("rst2_c2_mem_addr", mem_addr, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
